// File: rtl/debug_unit.sv
// debug_unit -- UART-driven debug controller for a small pipeline.
//
// Accepts single-byte commands from a UART receiver:
//   'L' N w0..wN-1 : load N 32-bit words (N=0 means 256) into instruction
//                    memory starting at word 0, each word sent MSB first.
//                    The cycle counter is cleared when the last word lands.
//   'C'            : run the pipeline until halt, then dump state.
//   'S'            : single-step the pipeline one cycle, then dump state.
// A dump is 7 words (pc, cycle counter, reg_16..reg_20) sent MSB first
// as 28 bytes over the transmitter, paced by tx_busy.
//
// Ports:
//   clk, reset (async, active-low)
//   rx_data[7:0], rx_valid       : received byte and its strobe
//   tx_data[7:0], tx_start       : byte to send and its launch strobe
//   tx_busy                      : transmitter busy
//   halt, pc[31:0], reg_16..reg_20[31:0] : pipeline observation taps
//   imem_we, imem_addr[7:0], imem_wdata[31:0] : instruction-memory write port
//   pipe_enable                  : clock enable for all pipeline stages
module debug_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic        halt,
  input  logic [31:0] pc,
  input  logic [31:0] reg_16,
  input  logic [31:0] reg_17,
  input  logic [31:0] reg_18,
  input  logic [31:0] reg_19,
  input  logic [31:0] reg_20,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        pipe_enable
);

  typedef enum logic [2:0] {
    IDLE, LOAD_CNT, LOAD_BYTE, RUN, STEP, DUMP_SNAP, DUMP_SEND, DUMP_WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [8:0]    words_left;   // words still to load, 1..256
  logic [1:0]    load_idx;     // byte position within the word being loaded
  logic [23:0]   asm_bytes;    // first three bytes of the word being loaded
  logic [4:0]    dump_idx;     // index of the byte currently in flight
  logic          skip;         // one-cycle hold-off before trusting tx_busy
  logic [223:0]  snap;         // dump shift register, next byte in the top 8 bits
  logic [31:0]   cycle_cnt;

  logic          word_done;
  assign word_done = (state == LOAD_BYTE) && rx_valid && (load_idx == 2'd3);

  always_comb begin
    state_nxt   = state;
    pipe_enable = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            8'h4C:   state_nxt = LOAD_CNT;
            8'h43:   state_nxt = RUN;
            8'h53:   state_nxt = STEP;
            default: state_nxt = IDLE;
          endcase
        end
      end
      LOAD_CNT:  if (rx_valid) state_nxt = LOAD_BYTE;
      // Leave as soon as the last byte arrives; the write strobe itself
      // lands in the following cycle regardless of state.
      LOAD_BYTE: if (word_done && (words_left == 9'd1)) state_nxt = IDLE;
      RUN: begin
        if (halt) state_nxt = DUMP_SNAP;
        else      pipe_enable = 1'b1;
      end
      STEP: begin
        pipe_enable = 1'b1;
        state_nxt   = DUMP_SNAP;
      end
      DUMP_SNAP: state_nxt = DUMP_SEND;
      DUMP_SEND: if (!tx_busy) state_nxt = DUMP_WAIT;
      DUMP_WAIT: begin
        if (!skip && !tx_busy)
          state_nxt = (dump_idx == 5'd27) ? IDLE : DUMP_SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      imem_we    <= 1'b0;
      imem_addr  <= 8'h00;
      imem_wdata <= 32'h0;
      words_left <= 9'd0;
      load_idx   <= 2'd0;
      asm_bytes  <= 24'h0;
      dump_idx   <= 5'd0;
      skip       <= 1'b0;
      snap       <= 224'h0;
      cycle_cnt  <= 32'h0;
    end else begin
      state    <= state_nxt;
      tx_start <= 1'b0;
      imem_we  <= 1'b0;
      // Address advances after every write and wraps naturally at 8 bits.
      if (imem_we)     imem_addr <= imem_addr + 8'd1;
      if (pipe_enable) cycle_cnt <= cycle_cnt + 32'd1;
      case (state)
        LOAD_CNT: begin
          if (rx_valid) begin
            words_left <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            load_idx   <= 2'd0;
            imem_addr  <= 8'h00;
          end
        end
        LOAD_BYTE: begin
          if (rx_valid) begin
            asm_bytes <= {asm_bytes[15:0], rx_data};
            load_idx  <= load_idx + 2'd1;
            if (load_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {asm_bytes, rx_data};
              words_left <= words_left - 9'd1;
              if (words_left == 9'd1) cycle_cnt <= 32'h0;
            end
          end
        end
        DUMP_SNAP: begin
          snap     <= {pc, cycle_cnt, reg_16, reg_17, reg_18, reg_19, reg_20};
          dump_idx <= 5'd0;
        end
        DUMP_SEND: begin
          if (!tx_busy) begin
            tx_data  <= snap[223:216];
            snap     <= {snap[215:0], 8'h00};
            tx_start <= 1'b1;
            skip     <= 1'b1;
          end
        end
        DUMP_WAIT: begin
          // The transmitter raises busy only the cycle after tx_start,
          // so the first cycle here is skipped before sampling it.
          if (skip) skip <= 1'b0;
          else if (!tx_busy && (dump_idx != 5'd27)) dump_idx <= dump_idx + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit -- self-checking bench for debug_unit.
// Drives UART command bytes, models a transmitter with a programmable busy
// time, records every imem write and tx byte, and compares them against
// expectations queued when each command is issued.
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] reg_16, reg_17, reg_18, reg_19, reg_20;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        pipe_enable;

  int tests = 0;
  int fails = 0;

  logic [39:0] act_wr_q[$];
  logic [39:0] exp_wr_q[$];
  logic [7:0]  act_tx_q[$];
  logic [7:0]  exp_tx_q[$];
  int pe_cnt    = 0;
  int busy_viol = 0;
  int busy_len  = 3;
  int busy_cnt  = 0;

  always #5 clk = ~clk;

  debug_unit dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .halt(halt),
    .pc(pc), .reg_16(reg_16), .reg_17(reg_17), .reg_18(reg_18),
    .reg_19(reg_19), .reg_20(reg_20), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .pipe_enable(pipe_enable)
  );

  // Output recorder, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_we) act_wr_q.push_back({imem_addr, imem_wdata});
      if (tx_start) begin
        act_tx_q.push_back(tx_data);
        if (tx_busy) busy_viol++;
      end
      if (pipe_enable) pe_cnt++;
    end
  end

  // Transmitter model: busy rises the cycle after tx_start, for busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_busy = (busy_cnt != 0);
      if (busy_cnt != 0) busy_cnt--;
      if (tx_start) busy_cnt = busy_len;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic push_dump(input logic [31:0] p, input logic [31:0] c);
    logic [31:0] w[7];
    w = '{p, c, reg_16, reg_17, reg_18, reg_19, reg_20};
    for (int i = 0; i < 7; i++)
      for (int b = 3; b >= 0; b--) exp_tx_q.push_back(w[i][8*b +: 8]);
  endtask

  task automatic set_regs(input logic [31:0] p, input logic [31:0] base_val);
    pc     = p;
    reg_16 = base_val;
    reg_17 = base_val + 32'h1111_0001;
    reg_18 = base_val + 32'h2222_0002;
    reg_19 = base_val + 32'h3333_0003;
    reg_20 = base_val + 32'h4444_0004;
  endtask

  task automatic test_reset;
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; halt = 1'b0;
    set_regs(32'h0, 32'h0);
    repeat (4) tick();
    tests++;
    if ({tx_start, imem_we, pipe_enable} !== 3'b000) begin
      fails++; $display("FAIL reset_strobes: got %b, expected 000", {tx_start, imem_we, pipe_enable});
    end
    tests++;
    if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %02h, expected 00", tx_data); end
    tests++;
    if (imem_addr !== 8'h00) begin fails++; $display("FAIL reset_imem_addr: got %02h, expected 00", imem_addr); end
    tests++;
    if (imem_wdata !== 32'h0) begin fails++; $display("FAIL reset_imem_wdata: got %08h, expected 0", imem_wdata); end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_load;
    logic [7:0] lb[10];
    logic [39:0] e;
    int wb;
    wb = act_wr_q.size();
    lb = '{8'h4C, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp_wr_q.push_back({8'h00, 32'h11223344});
    exp_wr_q.push_back({8'h01, 32'hAABBCCDD});
    for (int i = 0; i < 10; i++) send_byte(lb[i]);
    repeat (6) tick();
    tests++;
    if (act_wr_q.size() != wb + 2) begin
      fails++; $display("FAIL load_count: got %0d writes, expected 2", act_wr_q.size() - wb);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_wr_q.pop_front();
      if (wb + i < act_wr_q.size()) begin
        tests++;
        if (act_wr_q[wb+i] !== e) begin
          fails++; $display("FAIL load_write%0d: got %010h, expected %010h", i, act_wr_q[wb+i], e);
        end
      end
    end
    tests++;
    if (imem_wdata !== 32'hAABBCCDD) begin
      fails++; $display("FAIL load_wdata_hold: got %08h, expected aabbccdd", imem_wdata);
    end
    tests++;
    if (imem_addr !== 8'h02) begin fails++; $display("FAIL load_addr_after: got %02h, expected 02", imem_addr); end
  endtask

  // N=0 means 256 words, streamed with no gaps; address must wrap to 0.
  task automatic test_load_256;
    logic [31:0] w;
    logic [7:0]  wi;
    logic [39:0] e;
    int wb;
    wb = act_wr_q.size();
    tick(); rx_valid = 1'b1; rx_data = 8'h4C;
    tick(); rx_data = 8'h00;
    for (int k = 0; k < 256; k++) begin
      wi = k[7:0];
      w  = {wi, ~wi, wi ^ 8'h5A, 8'hC3};
      exp_wr_q.push_back({wi, w});
      for (int b = 3; b >= 0; b--) begin
        tick(); rx_data = w[8*b +: 8];
      end
    end
    tick(); rx_valid = 1'b0;
    repeat (5) tick();
    tests++;
    if (act_wr_q.size() != wb + 256) begin
      fails++; $display("FAIL load256_count: got %0d writes, expected 256", act_wr_q.size() - wb);
    end
    for (int i = 0; i < 256; i++) begin
      e = exp_wr_q.pop_front();
      if (wb + i < act_wr_q.size()) begin
        tests++;
        if (act_wr_q[wb+i] !== e) begin
          fails++; $display("FAIL load256_write%0d: got %010h, expected %010h", i, act_wr_q[wb+i], e);
        end
      end
    end
    tests++;
    if (imem_addr !== 8'h00) begin fails++; $display("FAIL load256_addr_wrap: got %02h, expected 00", imem_addr); end
  endtask

  task automatic test_run;
    logic [7:0] e;
    int base, pe0;
    set_regs(32'h0000_0028, 32'h0000_0005);
    push_dump(32'h0000_0028, 32'd10);
    base = act_tx_q.size();
    pe0  = pe_cnt;
    halt = 1'b0;
    send_byte(8'h43);
    for (int t = 0; t < 200 && (pe_cnt - pe0) < 10; t++) tick();
    halt = 1'b1;
    for (int t = 0; t < 3000 && act_tx_q.size() < base + 28; t++) tick();
    repeat (busy_len + 10) tick();
    halt = 1'b0;
    tests++;
    if (pe_cnt - pe0 != 10) begin fails++; $display("FAIL run_enables: got %0d, expected 10", pe_cnt - pe0); end
    tests++;
    if (act_tx_q.size() != base + 28) begin
      fails++; $display("FAIL run_len: got %0d bytes, expected 28", act_tx_q.size() - base);
    end
    for (int i = 0; i < 28; i++) begin
      e = exp_tx_q.pop_front();
      if (base + i < act_tx_q.size()) begin
        tests++;
        if (act_tx_q[base+i] !== e) begin
          fails++; $display("FAIL run_byte%0d: got %02h, expected %02h", i, act_tx_q[base+i], e);
        end
      end
    end
  endtask

  task automatic test_step;
    logic [7:0] lb[6];
    logic [7:0] e;
    int base, pe0, wb;
    // A one-word load clears the cycle counter first.
    wb = act_wr_q.size();
    lb = '{8'h4C, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 6; i++) send_byte(lb[i]);
    repeat (4) tick();
    tests++;
    if (act_wr_q.size() != wb + 1 || act_wr_q[act_wr_q.size()-1] !== {8'h00, 32'h01020304}) begin
      fails++; $display("FAIL step_preload: got %0d writes last %010h, expected 1 write 0001020304",
                        act_wr_q.size() - wb, act_wr_q[act_wr_q.size()-1]);
    end
    for (int k = 1; k <= 2; k++) begin
      set_regs(32'h0000_0100 + 32'(4*k), 32'h0BAD_0000 + 32'(k));
      push_dump(pc, 32'(k));
      base = act_tx_q.size();
      pe0  = pe_cnt;
      send_byte(8'h53);
      for (int t = 0; t < 3000 && act_tx_q.size() < base + 28; t++) tick();
      repeat (busy_len + 10) tick();
      tests++;
      if (pe_cnt - pe0 != 1) begin fails++; $display("FAIL step%0d_enables: got %0d, expected 1", k, pe_cnt - pe0); end
      tests++;
      if (act_tx_q.size() != base + 28) begin
        fails++; $display("FAIL step%0d_len: got %0d bytes, expected 28", k, act_tx_q.size() - base);
      end
      for (int i = 0; i < 28; i++) begin
        e = exp_tx_q.pop_front();
        if (base + i < act_tx_q.size()) begin
          tests++;
          if (act_tx_q[base+i] !== e) begin
            fails++; $display("FAIL step%0d_byte%0d: got %02h, expected %02h", k, i, act_tx_q[base+i], e);
          end
        end
      end
    end
  endtask

  task automatic test_halt_entry;
    logic [7:0] e;
    int base, pe0;
    set_regs(32'h0000_0200, 32'h7000_0000);
    push_dump(32'h0000_0200, 32'd2);
    base = act_tx_q.size();
    pe0  = pe_cnt;
    halt = 1'b1;
    send_byte(8'h43);
    for (int t = 0; t < 3000 && act_tx_q.size() < base + 28; t++) tick();
    repeat (busy_len + 10) tick();
    halt = 1'b0;
    tests++;
    if (pe_cnt - pe0 != 0) begin fails++; $display("FAIL halt_entry_enables: got %0d, expected 0", pe_cnt - pe0); end
    tests++;
    if (act_tx_q.size() != base + 28) begin
      fails++; $display("FAIL halt_entry_len: got %0d bytes, expected 28", act_tx_q.size() - base);
    end
    for (int i = 0; i < 28; i++) begin
      e = exp_tx_q.pop_front();
      if (base + i < act_tx_q.size()) begin
        tests++;
        if (act_tx_q[base+i] !== e) begin
          fails++; $display("FAIL halt_entry_byte%0d: got %02h, expected %02h", i, act_tx_q[base+i], e);
        end
      end
    end
  endtask

  task automatic test_flow_noise;
    logic [7:0] e;
    int base, pe0;
    busy_len = 50;
    set_regs(32'hFEDC_BA98, 32'h1234_5678);
    push_dump(32'hFEDC_BA98, 32'd3);
    base = act_tx_q.size();
    pe0  = pe_cnt;
    send_byte(8'h53);
    for (int t = 0; t < 5000 && act_tx_q.size() < base + 28; t++) begin
      tick();
      if (act_tx_q.size() > base && act_tx_q.size() < base + 28 && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b1; rx_data = 8'h53;
      end else begin
        rx_valid = 1'b0;
      end
    end
    rx_valid = 1'b0;
    repeat (busy_len + 60) tick();
    tests++;
    if (busy_viol != 0) begin fails++; $display("FAIL flow_busy_violations: got %0d, expected 0", busy_viol); end
    tests++;
    if (pe_cnt - pe0 != 1) begin fails++; $display("FAIL flow_enables: got %0d, expected 1", pe_cnt - pe0); end
    tests++;
    if (act_tx_q.size() != base + 28) begin
      fails++; $display("FAIL flow_len: got %0d bytes, expected 28", act_tx_q.size() - base);
    end
    for (int i = 0; i < 28; i++) begin
      e = exp_tx_q.pop_front();
      if (base + i < act_tx_q.size()) begin
        tests++;
        if (act_tx_q[base+i] !== e) begin
          fails++; $display("FAIL flow_byte%0d: got %02h, expected %02h", i, act_tx_q[base+i], e);
        end
      end
    end
    busy_len = 3;
  endtask

  task automatic test_reset_mid_load;
    logic [7:0] lb[7];
    logic [7:0] lb2[6];
    int wb;
    wb = act_wr_q.size();
    lb  = '{8'h4C, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    lb2 = '{8'h4C, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 7; i++) send_byte(lb[i]);
    reset = 1'b0;
    #1;
    tests++;
    if ({imem_we, tx_start, pipe_enable} !== 3'b000 || imem_addr !== 8'h00 || imem_wdata !== 32'h0 || tx_data !== 8'h00) begin
      fails++; $display("FAIL rst_load_outputs: got we/start/en %b addr %02h wdata %08h tx %02h, expected all zero",
                        {imem_we, tx_start, pipe_enable}, imem_addr, imem_wdata, tx_data);
    end
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    tests++;
    if (act_wr_q.size() != wb + 1) begin
      fails++; $display("FAIL rst_load_writes: got %0d writes, expected 1", act_wr_q.size() - wb);
    end
    for (int i = 0; i < 6; i++) send_byte(lb2[i]);
    repeat (4) tick();
    tests++;
    if (act_wr_q.size() != wb + 2 || act_wr_q[act_wr_q.size()-1] !== {8'h00, 32'hDEADBEEF}) begin
      fails++; $display("FAIL rst_fresh_load: got %0d writes last %010h, expected 2 writes last 00deadbeef",
                        act_wr_q.size() - wb, act_wr_q[act_wr_q.size()-1]);
    end
  endtask

  task automatic test_reset_mid_dump;
    int base;
    set_regs(32'hA5B6_C7D8, 32'h0);
    base = act_tx_q.size();
    send_byte(8'h53);
    for (int t = 0; t < 500 && act_tx_q.size() < base + 3; t++) tick();
    reset = 1'b0;
    #1;
    tests++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00) begin
      fails++; $display("FAIL rst_dump_outputs: got start %b data %02h, expected 0 00", tx_start, tx_data);
    end
    repeat (3) tick();
    reset = 1'b1;
    repeat (150) tick();
    tests++;
    if (act_tx_q.size() != base + 3) begin
      fails++; $display("FAIL rst_dump_strobes: got %0d bytes, expected 3", act_tx_q.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_256();
    test_run();
    test_step();
    test_halt_entry();
    test_flow_noise();
    test_reset_mid_load();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle strobe that launches tx_data.
- tx_busy  in  1  high while the transmitter is sending; goes high the cycle after tx_start.
- halt  in  1  pipeline has fetched its halt instruction; level signal.
- pc  in  32  current pipeline PC.
- reg_16, reg_17, reg_18, reg_19, reg_20  in  32 each  register file taps.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  8  instruction-memory word address.
- imem_wdata  out  32  instruction word to write.
- pipe_enable  out  1  clock enable for every pipeline stage.

Function
REQ-002 The FSM SHALL use states IDLE, LOAD_CNT, LOAD_BYTE, RUN, STEP, DUMP_SNAP, DUMP_SEND and DUMP_WAIT.
REQ-003 In IDLE, rx_valid with byte 0x4C ('L') SHALL go to LOAD_CNT, 0x43 ('C') SHALL go to RUN, and 0x53 ('S') SHALL go to STEP; all other bytes SHALL be ignored.
REQ-004 In LOAD_CNT, the next rx_valid byte SHALL be latched as the word count N, where 0 means 256; imem_addr SHALL be cleared to 0 and the FSM SHALL go to LOAD_BYTE.
REQ-005 In LOAD_BYTE, bytes SHALL be assembled most-significant byte first; the cycle after each 4th byte, imem_we SHALL pulse for one cycle with the assembled word on imem_wdata at the current imem_addr.
REQ-006 imem_addr SHALL increment by 1 after each write and SHALL wrap from 255 to 0.
REQ-007 After the N-th write, the FSM SHALL return to IDLE and the cycle counter SHALL clear to 0.
REQ-008 pipe_enable SHALL be high in RUN only while halt=0, and SHALL be high for exactly one cycle in STEP; it SHALL be low in every other state.
REQ-009 RUN SHALL move to DUMP_SNAP on the first cycle halt=1; if halt is already 1 on entry, zero pipeline cycles SHALL run.
REQ-010 STEP SHALL move to DUMP_SNAP after its single enabled cycle, regardless of halt.
REQ-011 The cycle counter SHALL be 32 bits, increment on each cycle with pipe_enable=1, and wrap from 0xFFFFFFFF to 0.
REQ-012 DUMP_SNAP SHALL capture, in one cycle, 7 words in this order: pc, cycle counter, reg_16, reg_17, reg_18, reg_19, reg_20.
REQ-013 DUMP_SEND SHALL send 28 bytes in total, each word most-significant byte first.
- tx_start SHALL pulse for one cycle with the byte on tx_data, issued only when tx_busy=0.
- The FSM SHALL then go to DUMP_WAIT, skip one cycle, and wait for tx_busy=0.
- After the 28th byte completes, the FSM SHALL return to IDLE.
REQ-014 rx_valid SHALL be ignored in RUN, STEP, DUMP_SNAP, DUMP_SEND and DUMP_WAIT; those bytes SHALL be lost and not queued.
REQ-015 If rx_valid and a pending imem write occur in the same cycle, the write SHALL complete and the byte SHALL be accepted as the next data byte.
REQ-016 tx_data SHALL hold its last value between strobes.
REQ-017 imem_wdata SHALL hold its last value between write strobes.

Reset
REQ-018 While reset=0, the block SHALL force:
- state to IDLE;
- tx_start, imem_we and pipe_enable to 0;
- tx_data, imem_addr and imem_wdata to 0;
- the cycle counter, byte index and snapshot to 0.
REQ-019 Reset asserted mid-load or mid-dump SHALL abort the operation immediately, with no further imem_we or tx_start pulses.

Verification
REQ-020 Load test: send 0x4C 0x02 then 11 22 33 44 AA BB CC DD. Required response: exactly two imem_we pulses, addr 0 with 0x11223344 and addr 1 with 0xAABBCCDD, then IDLE and counter=0.
REQ-021 Run test: send 0x43 with halt raised after 10 enabled cycles and pc=0x28, reg_16=5. Required response: 28 bytes beginning 00 00 00 28 00 00 00 0A 00 00 00 05.
REQ-022 Step test: send 0x53 twice. Required response: pipe_enable high for exactly 1 cycle each time; the counter field reads 1, then 2.
REQ-023 Halt-at-entry test: hold halt=1 and send 0x43. Required response: pipe_enable never rises; dump counter field equals the prior value.
REQ-024 Flow-control and noise test: hold tx_busy=1 for 50 cycles after each tx_start, and inject rx_valid bytes 0x53 during the dump. Required response: no tx_start while tx_busy=1; injected bytes are ignored; exactly 28 strobes.
REQ-025 Reset test: assert reset after 5 load bytes. Required response: outputs zero and state IDLE; a fresh 0x4C 0x01 load then writes addr 0.
